// File: rtl/laser310_bank_ctrl.sv
// Laser 310 expansion RAM window controller: B800h-FFFFh decode, lockable
// I/O-programmed bank register for C000h-FFFFh, and an SRAM wait-state generator.
`timescale 1ns/1ps

module laser310_bank_ctrl #(
    parameter int unsigned BANK_BITS   = 2,
    parameter logic [3:0]  IO_PORT     = 4'h7,
    parameter int unsigned RESET_BANK  = 1,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    input  logic [4:0]           Addr,
    input  logic [3:0]           AddrIO,
    input  logic                 WR_N,
    input  logic                 RD_N,
    input  logic                 MREQ_N,
    input  logic                 IORQ_N,
    input  logic [7:0]           D_IN,
    output logic [7:0]           D_OUT,
    output logic                 D_OE,
    output logic [BANK_BITS-1:0] RAM_AHI,
    output logic                 RAM_CS_N,
    output logic                 RAM_OE_N,
    output logic                 RAM_WE_N,
    output logic                 WAIT_N,
    output logic [BANK_BITS-1:0] bank,
    output logic                 locked,
    output logic                 led1,
    output logic                 led2
);

    localparam int unsigned          CNT_W     = 4;
    localparam logic [4:0]           WIN_LO    = 5'b10111;
    localparam logic [BANK_BITS-1:0] RST_BANK  = BANK_BITS'(RESET_BANK);
    localparam logic [CNT_W-1:0]     WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam bit                   WAIT_EN   = (WAIT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wait_n_q, wait_n_d;
    logic [2:0]           wr_sync_q, wr_sync_d;
    logic [2:0]           cs_sync_q, cs_sync_d;
    logic [BANK_BITS-1:0] bank_q, bank_d;
    logic                 locked_q, locked_d;

    logic                 in_win_c, ram_sel_c, io_wr_c, io_rd_c;
    logic                 wr_event_c, cs_fall_c, cs_high_c;
    logic [BANK_BITS-1:0] ram_ahi_c;
    logic [7:0]           d_out_c;
    logic                 unused_c;

    // Bus decode, all combinational from the Z80 strobes
    always_comb begin
        in_win_c  = (Addr >= WIN_LO);
        ram_sel_c = !MREQ_N && IORQ_N && in_win_c && (WR_N ^ RD_N);
        io_wr_c   = !IORQ_N && MREQ_N && !WR_N && RD_N && (AddrIO == IO_PORT);
        io_rd_c   = !IORQ_N && !RD_N && (AddrIO == IO_PORT);
    end

    // Page 0 belongs to B800h; a zero bank falls back to the reset page
    always_comb begin
        if (Addr == WIN_LO) begin
            ram_ahi_c = '0;
        end else if (bank_q == '0) begin
            ram_ahi_c = RST_BANK;
        end else begin
            ram_ahi_c = bank_q;
        end
    end

    always_comb begin
        d_out_c = '0;
        if (io_rd_c) begin
            d_out_c[BANK_BITS-1:0] = bank_q;
            d_out_c[7]             = locked_q;
        end
    end

    // Active-low synchronisers; bit 2 is the previous synchronised sample for edge detection
    always_comb begin
        wr_sync_d  = {wr_sync_q[1:0], !io_wr_c};
        cs_sync_d  = {cs_sync_q[1:0], !ram_sel_c};
        wr_event_c = !wr_sync_q[1] && wr_sync_q[2];
        cs_fall_c  = !cs_sync_q[1] && cs_sync_q[2];
        cs_high_c  = cs_sync_q[1];
    end

    always_comb begin
        bank_d   = bank_q;
        locked_d = locked_q;
        if (wr_event_c && !locked_q) begin
            bank_d   = D_IN[BANK_BITS-1:0];
            locked_d = D_IN[7];
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Early end of access takes priority over counter expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (WAIT_EN && cs_fall_c) state_d = S_WAIT;
            S_WAIT: begin
                if (cs_high_c) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: if (cs_high_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        wait_n_d = (state_d != S_WAIT);
        if (state_q == S_IDLE && state_d == S_WAIT) begin
            cnt_d = WAIT_LOAD;
        end else if (state_q == S_WAIT && state_d == S_WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_d != S_WAIT) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q     <= '0;
            wait_n_q  <= 1'b1;
            wr_sync_q <= 3'b111;
            cs_sync_q <= 3'b111;
            bank_q    <= RST_BANK;
            locked_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wait_n_q  <= wait_n_d;
            wr_sync_q <= wr_sync_d;
            cs_sync_q <= cs_sync_d;
            bank_q    <= bank_d;
            locked_q  <= locked_d;
        end
    end

    assign unused_c = ^D_IN;

    assign RAM_CS_N = !ram_sel_c;
    assign RAM_OE_N = !ram_sel_c || !WR_N;
    assign RAM_WE_N = !ram_sel_c || WR_N;
    assign RAM_AHI  = ram_ahi_c;
    assign D_OUT    = d_out_c;
    assign D_OE     = io_rd_c;
    assign WAIT_N   = wait_n_q;
    assign bank     = bank_q;
    assign locked   = locked_q;
    assign led1     = ram_sel_c;
    assign led2     = !(!ram_sel_c || WR_N);

endmodule

// File: tb/tb_laser310_bank_ctrl.sv
// Scoreboard bench for laser310_bank_ctrl: a default instance and a 4-bit-bank,
// 3-wait-cycle instance share one Z80 bus and are checked against a reference model.
`timescale 1ns/1ps

module tb_laser310_bank_ctrl;

    localparam int WAIT_B = 3;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [4:0] Addr;
    logic [3:0] AddrIO;
    logic       WR_N, RD_N, MREQ_N, IORQ_N;
    logic [7:0] D_IN;

    logic [7:0] a_d_out, b_d_out;
    logic       a_d_oe, b_d_oe;
    logic [1:0] a_ahi, a_bank;
    logic [3:0] b_ahi, b_bank;
    logic       a_cs_n, a_oe_n, a_we_n, a_wait_n, a_locked, a_led1, a_led2;
    logic       b_cs_n, b_oe_n, b_we_n, b_wait_n, b_locked, b_led1, b_led2;

    always #5 clk = ~clk;

    laser310_bank_ctrl dut_a (
        .clk(clk), .RESET_N(RESET_N), .Addr(Addr), .AddrIO(AddrIO),
        .WR_N(WR_N), .RD_N(RD_N), .MREQ_N(MREQ_N), .IORQ_N(IORQ_N), .D_IN(D_IN),
        .D_OUT(a_d_out), .D_OE(a_d_oe), .RAM_AHI(a_ahi), .RAM_CS_N(a_cs_n),
        .RAM_OE_N(a_oe_n), .RAM_WE_N(a_we_n), .WAIT_N(a_wait_n), .bank(a_bank),
        .locked(a_locked), .led1(a_led1), .led2(a_led2)
    );

    laser310_bank_ctrl #(.BANK_BITS(4), .IO_PORT(4'h7), .RESET_BANK(1), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk(clk), .RESET_N(RESET_N), .Addr(Addr), .AddrIO(AddrIO),
        .WR_N(WR_N), .RD_N(RD_N), .MREQ_N(MREQ_N), .IORQ_N(IORQ_N), .D_IN(D_IN),
        .D_OUT(b_d_out), .D_OE(b_d_oe), .RAM_AHI(b_ahi), .RAM_CS_N(b_cs_n),
        .RAM_OE_N(b_oe_n), .RAM_WE_N(b_we_n), .WAIT_N(b_wait_n), .bank(b_bank),
        .locked(b_locked), .led1(b_led1), .led2(b_led2)
    );

    typedef struct {
        string       tag;
        logic [23:0] ea;
        logic [23:0] eb;
    } exp_t;

    exp_t  sbq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    m_bank_a, m_lock_a, m_bank_b, m_lock_b;
    string cur_op = "init";

    // Observation word: {d_oe, d_out, ahi, cs_n, oe_n, we_n, wait_n, bank, locked, led1, led2}
    function automatic logic [23:0] model_obs(input int bnk, input int lck, input bit w);
        bit   win, mem, rd, cs, oe, we;
        int   ahi;
        logic [7:0] dout;
        win  = (Addr >= 5'd23);
        mem  = !MREQ_N && IORQ_N && (WR_N != RD_N) && win;
        ahi  = (Addr == 5'd23) ? 0 : ((bnk == 0) ? 1 : bnk);
        cs   = !mem;
        oe   = cs || !WR_N;
        we   = cs || WR_N;
        rd   = !IORQ_N && !RD_N && (AddrIO == 4'h7);
        dout = rd ? 8'((lck * 128) + bnk) : 8'd0;
        return {rd, dout, 4'(ahi), cs, oe, we, w, 4'(bnk), lck[0], !cs, !we};
    endfunction

    function automatic void model_reset();
        m_bank_a = 1; m_lock_a = 0;
        m_bank_b = 1; m_lock_b = 0;
    endfunction

    function automatic void model_io_write(input logic [7:0] d);
        if (m_lock_a == 0) begin
            m_bank_a = int'(d) % 4;
            m_lock_a = int'(d[7]);
        end
        if (m_lock_b == 0) begin
            m_bank_b = int'(d) % 16;
            m_lock_b = int'(d[7]);
        end
    endfunction

    task automatic push(input int k, input bit wa, input bit wb);
        exp_t e;
        e.tag = $sformatf("%s@%0d", cur_op, k);
        e.ea  = model_obs(m_bank_a, m_lock_a, wa);
        e.eb  = model_obs(m_bank_b, m_lock_b, wb);
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        MREQ_N = 1'b1; IORQ_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1;
    endtask

    // rw: 0 read, 1 write, 2 both strobes low (illegal, no select)
    task automatic mem_access(input logic [4:0] a, input int rw, input int len);
        bit act;
        int lim;
        cur_op = $sformatf("mem_a%02h_rw%0d_len%0d", a, rw, len);
        act    = (a >= 5'd23) && (rw != 2);
        lim    = (len < WAIT_B) ? len + 2 : WAIT_B + 2;
        Addr   = a; D_IN = 8'($urandom);
        MREQ_N = 1'b0; IORQ_N = 1'b1;
        RD_N   = (rw == 1); WR_N = (rw == 0);
        for (int k = 0; k <= len + 4; k++) begin
            if (k == len) bus_idle();
            push(k, 1'b1, !(act && k >= 3 && k <= lim));
            tick();
        end
    endtask

    task automatic io_write(input logic [3:0] port, input logic [7:0] d, input bit both, input int len);
        cur_op = $sformatf("iow_p%0h_d%02h_b%0d", port, d, both);
        Addr   = 5'($urandom); AddrIO = port; D_IN = d;
        IORQ_N = 1'b0; MREQ_N = both ? 1'b0 : 1'b1; WR_N = 1'b0; RD_N = 1'b1;
        for (int k = 0; k <= len + 3; k++) begin
            if (k == 3 && port == 4'h7 && !both) model_io_write(d);
            if (k == len) bus_idle();
            push(k, 1'b1, 1'b1);
            tick();
        end
    endtask

    task automatic io_read(input logic [3:0] port);
        cur_op = $sformatf("ior_p%0h", port);
        AddrIO = port; Addr = 5'($urandom);
        IORQ_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1; MREQ_N = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            if (k == 2) bus_idle();
            push(k, 1'b1, 1'b1);
            tick();
        end
    endtask

    // mode 0: reset in the middle of a wait; mode 1: reset before a write lands
    task automatic reset_mid(input int mode);
        cur_op = $sformatf("reset_mid%0d", mode);
        if (mode == 0) begin
            Addr = 5'b11100; MREQ_N = 1'b0; IORQ_N = 1'b1; RD_N = 1'b0; WR_N = 1'b1;
            for (int k = 0; k <= 3; k++) begin
                push(k, 1'b1, !(k >= 3));
                tick();
            end
        end else begin
            AddrIO = 4'h7; D_IN = 8'($urandom); IORQ_N = 1'b0; MREQ_N = 1'b1; WR_N = 1'b0; RD_N = 1'b1;
            for (int k = 0; k <= 1; k++) begin
                push(k, 1'b1, 1'b1);
                tick();
            end
        end
        RESET_N = 1'b0;
        model_reset();
        push(10, 1'b1, 1'b1);
        tick();
        bus_idle();
        for (int k = 11; k <= 12; k++) begin
            push(k, 1'b1, 1'b1);
            tick();
        end
        RESET_N = 1'b1;
        for (int k = 13; k <= 17; k++) begin
            push(k, 1'b1, 1'b1);
            tick();
        end
    endtask

    // Monitor: compares every pending expectation against both instances at the falling edge
    always @(negedge clk) begin
        exp_t        e;
        logic [23:0] oa, ob;
        while (sbq.size() > 0) begin
            e  = sbq.pop_front();
            oa = {a_d_oe, a_d_out, 4'(a_ahi), a_cs_n, a_oe_n, a_we_n, a_wait_n, 4'(a_bank), a_locked, a_led1, a_led2};
            ob = {b_d_oe, b_d_out, b_ahi, b_cs_n, b_oe_n, b_we_n, b_wait_n, b_bank, b_locked, b_led1, b_led2};
            n_checks++;
            if (oa === e.ea) n_pass++;
            else $display("FAIL %s dut_a got %06h want %06h", e.tag, oa, e.ea);
            n_checks++;
            if (ob === e.eb) n_pass++;
            else $display("FAIL %s dut_b got %06h want %06h", e.tag, ob, e.eb);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0] port;
        RESET_N = 1'b0;
        bus_idle();
        Addr = '0; AddrIO = '0; D_IN = '0;
        model_reset();
        tick();
        cur_op = "reset_state";
        push(0, 1'b1, 1'b1);
        tick();
        RESET_N = 1'b1;
        push(1, 1'b1, 1'b1);
        tick();

        mem_access(5'b11000, 0, 2);
        mem_access(5'b10111, 0, 2);
        io_write(4'h7, 8'h03, 1'b0, 4);
        io_read(4'h7);
        mem_access(5'b11111, 1, 2);
        io_write(4'h7, 8'h82, 1'b0, 4);
        io_write(4'h7, 8'h01, 1'b0, 5);
        io_read(4'h7);
        reset_mid(0);
        io_write(4'h7, 8'h0A, 1'b0, 4);
        mem_access(5'b11010, 0, 3);
        io_write(4'h7, 8'h00, 1'b0, 4);
        mem_access(5'b11010, 1, 3);
        mem_access(5'b11100, 0, 8);
        mem_access(5'b11100, 0, 1);
        mem_access(5'b11100, 1, 2);
        for (int a = 0; a < 23; a += 5) mem_access(5'(a), a % 2, 2);
        mem_access(5'b10110, 0, 4);
        io_write(4'h6, 8'h05, 1'b0, 4);
        io_read(4'h6);
        io_write(4'h7, 8'h05, 1'b1, 4);
        reset_mid(1);

        for (int i = 0; i < 150; i++) begin
            r    = $urandom_range(0, 19);
            port = ($urandom_range(0, 3) != 0) ? 4'h7 : 4'($urandom);
            if (r < 8) begin
                mem_access((r % 2 == 1) ? 5'($urandom_range(23, 31)) : 5'($urandom),
                           $urandom_range(0, 2), $urandom_range(1, 7));
            end else if (r < 13) begin
                io_write(port, 8'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(4, 6));
            end else if (r < 18) begin
                io_read(port);
            end else begin
                reset_mid($urandom_range(0, 1));
            end
        end

        repeat (2) @(negedge clk);
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain pending %0d want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
